led_pwm_ctrl: RTL

LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

---
 rtl/led_pwm_ctrl_pkg.sv | 46 ++++
 rtl/led_pwm_ctrl_if.sv | 13 +
 rtl/led_pwm_channel.sv | 31 +++
 rtl/led_pwm_ctrl.sv | 89 ++++++++
 4 files changed

// File: rtl/led_pwm_ctrl_pkg.sv
// rtl/led_pwm_ctrl_pkg.sv - register map, bus width and address decode shared by the LED PWM controller
package led_pwm_ctrl_pkg;

    localparam int BUS_W = 16;

    localparam logic [15:0] LED_OFS   = 16'd0;
    localparam logic [15:0] MODE_OFS  = 16'd2;
    localparam logic [15:0] DUTY_BASE = 16'd4;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_LED,
        REG_MODE,
        REG_DUTY
    } reg_kind_e;

    typedef struct packed {
        reg_kind_e  kind;
        logic [3:0] idx;
    } reg_sel_t;

    // addr is a word address; registers live at even byte offsets from base
    function automatic reg_sel_t decode_addr(input logic [15:0] addr,
                                             input logic [15:0] base,
                                             input int unsigned num_regs);
        logic [15:0] byte_addr;
        logic [15:0] off;
        logic [15:0] duty_end;
        reg_sel_t    sel;
        byte_addr = {addr[14:0], 1'b0};
        off       = byte_addr - base;
        duty_end  = DUTY_BASE + 16'(2 * num_regs);
        sel.kind  = REG_NONE;
        sel.idx   = '0;
        if (off == LED_OFS) begin
            sel.kind = REG_LED;
        end else if (off == MODE_OFS) begin
            sel.kind = REG_MODE;
        end else if (off >= DUTY_BASE && off < duty_end && !off[0]) begin
            sel.kind = REG_DUTY;
            sel.idx  = 4'((off - DUTY_BASE) >> 1);
        end
        return sel;
    endfunction

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// rtl/led_pwm_ctrl_if.sv - register bus between host and LED PWM controller
interface led_pwm_ctrl_if;
    import led_pwm_ctrl_pkg::*;

    logic             en;
    logic             wr_en;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] data;
    logic [BUS_W-1:0] rd_data;

    modport master (output en, output wr_en, output addr, output data, input rd_data);
    modport slave  (input en, input wr_en, input addr, input data, output rd_data);
endinterface

// File: rtl/led_pwm_channel.sv
// rtl/led_pwm_channel.sv - one LED channel: duty register, mode bit, compare and output flop
module led_pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                duty_we,
    input  logic [PWM_BITS-1:0] duty_wdata,
    input  logic                mode_we,
    input  logic                mode_wdata,
    input  logic                led_static,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] duty,
    output logic                mode,
    output logic                led_out
);

    // compare uses pre-edge duty/mode, so a write shows on led_out one edge later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty    <= '0;
            mode    <= 1'b0;
            led_out <= 1'b0;
        end else begin
            if (duty_we) duty <= duty_wdata;
            if (mode_we) mode <= mode_wdata;
            led_out <= mode ? (pwm_cnt < duty) : led_static;
        end
    end

endmodule

// File: rtl/led_pwm_ctrl.sv
// rtl/led_pwm_ctrl.sv - LED controller top: prescaler, PWM counter, register decode and readback
module led_pwm_ctrl
    import led_pwm_ctrl_pkg::*;
#(
    parameter int          NUM_LEDS  = 8,
    parameter int          PWM_BITS  = 8,
    parameter int          PRESCALE  = 1,
    parameter logic [15:0] BASE_ADDR = 16'hff00
) (
    input  logic                clk,
    input  logic                rst,
    led_pwm_ctrl_if.slave       bus,
    output logic [NUM_LEDS-1:0] led_out
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]     ps_cnt;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [NUM_LEDS-1:0] led_reg;
    logic [NUM_LEDS-1:0] mode_vec;
    logic [PWM_BITS-1:0] duty_vec [NUM_LEDS];
    logic [BUS_W-1:0]    rd_next;
    logic                wr_acc;
    logic                rd_acc;
    reg_sel_t            sel;
    logic                unused_bits;

    assign sel         = decode_addr(bus.addr, BASE_ADDR, NUM_LEDS);
    assign wr_acc      = bus.en & bus.wr_en;
    assign rd_acc      = bus.en & ~bus.wr_en;
    assign tick        = (ps_cnt == PS_W'(PRESCALE - 1));
    assign unused_bits = ^{bus.addr[15], bus.data};

    // free-running timebase; bus traffic never touches it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_cnt  <= '0;
            pwm_cnt <= '0;
        end else begin
            ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    always_comb begin
        rd_next = '0;
        case (sel.kind)
            REG_LED:  rd_next[NUM_LEDS-1:0] = led_reg;
            REG_MODE: rd_next[NUM_LEDS-1:0] = mode_vec;
            REG_DUTY: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (sel.idx == 4'(i)) rd_next[PWM_BITS-1:0] = duty_vec[i];
                end
            end
            default:  rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_reg     <= '0;
            bus.rd_data <= '0;
        end else begin
            if (wr_acc && sel.kind == REG_LED) led_reg <= bus.data[NUM_LEDS-1:0];
            if (rd_acc) bus.rd_data <= rd_next;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .duty_we   (wr_acc && sel.kind == REG_DUTY && sel.idx == 4'(i)),
            .duty_wdata(bus.data[PWM_BITS-1:0]),
            .mode_we   (wr_acc && sel.kind == REG_MODE),
            .mode_wdata(bus.data[i]),
            .led_static(led_reg[i]),
            .pwm_cnt   (pwm_cnt),
            .duty      (duty_vec[i]),
            .mode      (mode_vec[i]),
            .led_out   (led_out[i])
        );
    end

endmodule
